// File: rtl/multdiv_iterative.sv
// Iterative signed multiply/divide: one shift-add or restoring-divide step per cycle
// on operand magnitudes, with sign correction applied on the final step.
module multdiv_iterative #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // acc holds {high, low}: product accumulator/multiplier for MULT,
  // remainder/dividend-quotient for DIV
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic               neg_q, neg_d, div0_q, div0_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               exc_q, exc_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum, trial;
  logic [WIDTH+1:0]   diff;
  logic               ge;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod_s;
  logic [WIDTH-1:0]   quo, quo_s;
  logic               last;

  always_comb begin
    a_mag   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    b_mag   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mag_q : '0)};
    mul_nxt = {sum, acc_q[WIDTH-1:1]};

    // 33-bit trial remainder so a 2^31 magnitude never wraps
    trial   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff    = {1'b0, trial} - {2'b00, mag_q};
    ge      = ~diff[WIDTH+1];
    rem     = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    div_nxt = {rem, acc_q[WIDTH-2:0], ge};

    prod_s  = neg_q ? -mul_nxt : mul_nxt;
    quo     = div_nxt[WIDTH-1:0];
    quo_s   = neg_q ? -quo : quo;
    last    = (cnt_q == CNT_W'(WIDTH-1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    div0_d  = div0_q;
    res_d   = res_q;
    exc_d   = exc_q;
    if (ctrl_MULT || ctrl_DIV) begin
      state_d = ctrl_MULT ? S_MULT : S_DIV;
      cnt_d   = '0;
      acc_d   = {{WIDTH{1'b0}}, (ctrl_MULT ? b_mag : a_mag)};
      mag_d   = ctrl_MULT ? a_mag : b_mag;
      neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div0_d  = ~ctrl_MULT && (data_operandB == '0);
    end else begin
      case (state_q)
        S_MULT: begin
          acc_d = mul_nxt;
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            state_d = S_DONE;
            res_d   = prod_s[WIDTH-1:0];
            exc_d   = ~((&prod_s[2*WIDTH-1:WIDTH-1]) | ~(|prod_s[2*WIDTH-1:WIDTH-1]));
          end
        end
        S_DIV: begin
          acc_d = div_nxt;
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            state_d = S_DONE;
            res_d   = div0_q ? '0 : quo_s;
            // only MIN / -1 yields a positive quotient of magnitude 2^31
            exc_d   = div0_q | (~neg_q & quo[WIDTH-1]);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      div0_q  <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      div0_q  <= div0_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == S_DONE);
  assign busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_multdiv_iterative.sv
// Directed table-driven bench for multdiv_iterative plus restart/reset sequences.
module tb_multdiv_iterative;
  logic        clock, reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int tests = 0;
  int fails = 0;

  multdiv_iterative #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .reset(reset),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    bit          mult;
    bit          div;
    logic [31:0] res;
    bit          exc;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Start at an edge, then watch 34 edges: RDY must pulse only after edge 32
  // and busy must fall at edge 33.
  task automatic run_vec(input vec_t v);
    int nrdy, rdy_at;
    logic busy32, busy33;
    nrdy = 0; rdy_at = -1; busy32 = 1'b0; busy33 = 1'b1;
    @(negedge clock);
    data_operandA = v.a; data_operandB = v.b;
    ctrl_MULT = v.mult; ctrl_DIV = v.div;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;
    chk({v.name, " busy_after_start"}, {31'b0, busy}, 32'd1);
    for (int k = 1; k <= 34; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin nrdy++; rdy_at = k; end
      if (k == 32) busy32 = busy;
      if (k == 33) busy33 = busy;
    end
    chk({v.name, " rdy_count"}, nrdy, 32'd1);
    chk({v.name, " rdy_edge"}, rdy_at, 32'd32);
    chk({v.name, " busy_at32"}, {31'b0, busy32}, 32'd1);
    chk({v.name, " busy_at33"}, {31'b0, busy33}, 32'd0);
    chk({v.name, " result"}, data_result, v.res);
    chk({v.name, " exception"}, {31'b0, data_exception}, {31'b0, v.exc});
  endtask

  vec_t vecs[12];
  vec_t tmp;

  initial begin
    int nrdy, rdy_at;
    vecs[0]  = '{"mul_7x-6",     32'd7,        32'hFFFFFFFA, 1, 0, 32'hFFFFFFD6, 0};
    vecs[1]  = '{"mul_ovf_2^32", 32'h00010000, 32'h00010000, 1, 0, 32'h00000000, 1};
    vecs[2]  = '{"mul_-1xmin",   32'hFFFFFFFF, 32'h80000000, 1, 0, 32'h80000000, 1};
    vecs[3]  = '{"mul_0x-5",     32'd0,        32'hFFFFFFFB, 1, 0, 32'h00000000, 0};
    vecs[4]  = '{"mul_minx1",    32'h80000000, 32'd1,        1, 0, 32'h80000000, 0};
    vecs[5]  = '{"div_-100/7",   32'hFFFFFF9C, 32'd7,        0, 1, 32'hFFFFFFF2, 0};
    vecs[6]  = '{"div_100/-7",   32'd100,      32'hFFFFFFF9, 0, 1, 32'hFFFFFFF2, 0};
    vecs[7]  = '{"div_-100/-7",  32'hFFFFFF9C, 32'hFFFFFFF9, 0, 1, 32'h0000000E, 0};
    vecs[8]  = '{"div_5/0",      32'd5,        32'd0,        0, 1, 32'h00000000, 1};
    vecs[9]  = '{"div_min/-1",   32'h80000000, 32'hFFFFFFFF, 0, 1, 32'h80000000, 1};
    vecs[10] = '{"div_3/5",      32'd3,        32'd5,        0, 1, 32'h00000000, 0};
    vecs[11] = '{"div_min/1",    32'h80000000, 32'd1,        0, 1, 32'h80000000, 0};

    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = '0; data_operandB = '0;
    #12;
    chk("reset result", data_result, 32'd0);
    chk("reset flags", {28'b0, data_exception, data_resultRDY, busy, 1'b0}, 32'd0);
    @(negedge clock); reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Restart: MULT 3x4 at edge 0 overridden by DIV 100/3 at edge 10.
    nrdy = 0; rdy_at = -1;
    @(negedge clock);
    data_operandA = 32'd3; data_operandB = 32'd4; ctrl_MULT = 1'b1;
    @(posedge clock); #1; ctrl_MULT = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      if (k == 10) begin
        @(negedge clock);
        data_operandA = 32'd100; data_operandB = 32'd3; ctrl_DIV = 1'b1;
      end
      @(posedge clock); #1;
      if (k == 10) ctrl_DIV = 1'b0;
      if (data_resultRDY) begin nrdy++; rdy_at = k; end
    end
    chk("restart rdy_count", nrdy, 32'd1);
    chk("restart rdy_edge", rdy_at, 32'd42);
    chk("restart result", data_result, 32'd33);

    // Asynchronous reset mid-multiply aborts with no strobe afterwards.
    @(negedge clock);
    data_operandA = 32'd7; data_operandB = 32'd9; ctrl_MULT = 1'b1;
    @(posedge clock); #1; ctrl_MULT = 1'b0;
    repeat (20) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("midreset result", data_result, 32'd0);
    chk("midreset flags", {29'b0, data_exception, data_resultRDY, busy}, 32'd0);
    @(negedge clock); reset = 1'b0;
    nrdy = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY) nrdy++;
    end
    chk("midreset no_rdy", nrdy, 32'd0);

    tmp = '{"div_9/3", 32'd9, 32'd3, 0, 1, 32'd3, 0};
    run_vec(tmp);
    tmp = '{"both_6,3", 32'd6, 32'd3, 1, 1, 32'd18, 0};
    run_vec(tmp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
